// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sequencer slice.
//   - OP_ADD..OP_SHR : ALU select codes, in the same order as the ALU result mux.
//   - state_e        : sequencer FSM states.
//   - W_DEF, CW_DEF  : default data width and repeat-count width.
package alu_pkg;

  localparam int unsigned W_DEF  = 8;
  localparam int unsigned CW_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_INV = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the command port, the ALU operand/result loop and the
// result port of the sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_cnt/cmd_use_acc : command handshake
//   opA/opB/opS (to ALU), R (from ALU)                          : ALU loop
//   res_valid/res_ready/res_data/res_zero                       : result handshake
// Modports: slave = sequencer view, master = surrounding logic (source/ALU/sink).
interface alu_sequencer_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_use_acc;

  logic [W-1:0]  opA;
  logic [W-1:0]  opB;
  logic [2:0]    opS;
  logic [W-1:0]  R;

  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_zero;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, cmd_use_acc, R, res_ready,
    output cmd_ready, opA, opB, opS, res_valid, res_data, res_zero
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cnt, cmd_use_acc, R, res_ready,
    input  cmd_ready, opA, opB, opS, res_valid, res_data, res_zero
  );

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: iterative front end for the combinational ALU.
// Accepts a command, feeds the accumulator through the ALU cmd_cnt+1 times with a
// fixed second operand and opcode, then offers the accumulator on the result port.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_sequencer_if.slave (command, ALU loop, result)
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  state_e        r_state, w_state_nxt;
  logic [W-1:0]  r_acc,   w_acc_nxt;
  logic [W-1:0]  r_b,     w_b_nxt;
  logic [2:0]    r_op,    w_op_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          w_cmd_fire;

  assign w_cmd_fire = bus.cmd_valid && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_acc_nxt   = bus.cmd_use_acc ? r_acc : bus.cmd_a;
          w_b_nxt     = bus.cmd_b;
          w_op_nxt    = bus.cmd_op;
          w_cnt_nxt   = bus.cmd_cnt;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // One ALU pass per cycle; cnt counts the passes still owed after this one.
        w_acc_nxt = bus.R;
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_DONE: begin
        // acc is deliberately kept so the next command can chain from it.
        if (bus.res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ALU operands come straight from registers: no path from cmd_* into the loop.
  assign bus.opA       = r_acc;
  assign bus.opB       = r_b;
  assign bus.opS       = r_op;

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.res_valid = (r_state == ST_DONE);
  assign bus.res_data  = r_acc;
  assign bus.res_zero  = (r_acc == '0);

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential front end for the 8-bit combinational ALU. It accepts operation commands over a valid/ready handshake and drives the ALU's `opA`/`opB`/`opS` inputs. It feeds the ALU result `R` back into an internal accumulator for a programmable number of passes, then presents the final value on a valid/ready result port. It sits directly upstream of the ALU, closes the loop around it, and gives the datapath iterative operation (repeated shifts, multiply-by-add, accumulate chains).

## Interface
Parameters:
- `W`, 8, data width; must match the ALU's operand width.
- `CW`, 4, width of the repeat count; maximum passes = 2^CW.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  ALU select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV, 6 SHL, 7 SHR.
- `cmd_a`  in  W  first operand; ignored when `cmd_use_acc`=1.
- `cmd_b`  in  W  second operand, held constant for all passes.
- `cmd_cnt`  in  CW  extra passes; total passes = `cmd_cnt`+1.
- `cmd_use_acc`  in  1  seed the first operand from the current accumulator instead of `cmd_a`.
- `opA`, `opB`  out  W  to the ALU.
- `opS`  out  3  to the ALU.
- `R`  in  W  ALU result (combinational from `opA`/`opB`/`opS`).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  W  final accumulator value.
- `res_zero`  out  1  `res_data` == 0.

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: `acc` <= (`cmd_use_acc` ? `acc` : `cmd_a`); `b_reg` <= `cmd_b`; `op_reg` <= `cmd_op`; `cnt` <= `cmd_cnt`; go to EXEC.
- **EXEC**
  - `cmd_ready`=0, `res_valid`=0.
  - Each cycle: `acc` <= `R`.
  - If `cnt`==0, go to DONE; else `cnt` <= `cnt`-1.
- **DONE**
  - `res_valid`=1; `res_data`=`acc`; `res_zero`=(`acc`==0).
  - Holds until `res_valid`&&`res_ready`, then goes to IDLE.
  - `acc` is retained after the result is accepted, for later `cmd_use_acc` chaining.
- `opA`=`acc`, `opB`=`b_reg`, `opS`=`op_reg` continuously, from registers only; no combinational path from `cmd_*` to the ALU.
- Arithmetic is modulo 2^W; wrap-around is silent; no carry or overflow output.
- `cmd_ready` is a function of state only. It never depends on `cmd_valid`.
- `res_valid` never deasserts without a handshake.
- `res_data` is stable while `res_valid`=1.
- Reset (asynchronous, any state, including mid-EXEC):
  - state=IDLE; `acc`, `b_reg`, `op_reg`, `cnt` = 0.
  - Outputs: `cmd_ready`=1, `res_valid`=0, `res_data`=0, `res_zero`=1, `opA`=`opB`=0, `opS`=0.
  - An in-flight command is discarded; no result is produced for it.

## Timing
- Command handshake at edge E0. EXEC occupies cycles E0..E0+`cmd_cnt`.
- `res_valid` rises after edge E0+`cmd_cnt`+1. Latency = `cmd_cnt`+2 edges, including the accept edge.
- Result handshake at edge Ek leaves `cmd_ready`=1 in the following cycle.
- Minimum command spacing = `cmd_cnt`+3 cycles (no overlap of a command with a pending result).
- A command presented while `cmd_ready`=0 is not accepted. The source holds it (standard valid/ready).

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_ADD`..`OP_SHR` (0..7), matching the ALU mux order.
  - state enum `{ST_IDLE, ST_EXEC, ST_DONE}`.
  - default widths W=8, CW=4.
- Single module, no sub-modules. The ALU is instantiated beside it at the next level up, not inside.
- One always block for the async-reset sequential state; combinational output assigns.

## Test plan
- ADD, `cmd_a`=3, `cmd_b`=5, `cmd_cnt`=0, `res_ready`=1 → `res_data`=8, `res_zero`=0, `res_valid` high exactly 2 edges after accept for 1 cycle.
- ADD, `cmd_a`=10, `cmd_b`=1, `cmd_cnt`=3 → `res_data`=14 after 5 edges; `opA` sequence 10, 11, 12, 13.
- SUB, `cmd_a`=0, `cmd_b`=1, `cmd_cnt`=0 → `res_data`=0xFF (wrap). Then SUB with `cmd_use_acc`=1, `cmd_b`=0xFF → `res_data`=0, `res_zero`=1.
- INV, `cmd_a`=0xA5, `cmd_cnt`=1 → `res_data`=0xA5. With `res_ready` held low 10 cycles: `res_valid` and `res_data` stable; `cmd_ready`=0; a `cmd_valid` pulse during this time is not accepted.
- ADD, `cmd_cnt`=15, `rst_n` asserted mid-EXEC → same cycle: `cmd_ready`=1, `res_valid`=0, `opA`=0. After release, a fresh ADD 2+2 → 4.
- Back-to-back commands with `cmd_valid` held high and `res_ready`=1 → the second accept occurs exactly on the cycle after the first result handshake.
